// File: rtl/scan_select_sequencer_pkg.sv
// Shared state encoding and default sizing for the scan select sequencer.
package scan_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_SEL_W        = 2;
    localparam int DEF_DWELL_W      = 8;
    localparam int DEF_BLANK_CYCLES = 1;

endpackage

// File: rtl/scan_select_sequencer_next_code_finder.sv
// Combinational search over a code mask: next set bit above the current index,
// lowest set bit (wrap target), and whether the current index is the last one.
module next_code_finder
    import scan_seq_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [2**SEL_W-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    next_above,
    output logic [SEL_W-1:0]    lowest,
    output logic                is_last
);

    localparam int N = 2**SEL_W;

    logic [N-1:0] above;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_above
            assign above[gi] = mask[gi] && (gi > int'(cur));
        end
    endgenerate

    function automatic logic [SEL_W-1:0] lowest_set(input logic [N-1:0] v);
        lowest_set = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = SEL_W'(i);
            end
        end
    endfunction

    assign next_above = lowest_set(above);
    assign lowest     = lowest_set(mask);
    assign is_last    = ~|above;

endmodule

// File: rtl/scan_select_sequencer.sv
// Timed select/enable generator feeding a 2**SEL_W-way decoder: walks the
// enabled codes in ascending order with a programmable dwell and blanking.
module scan_select_sequencer
    import scan_seq_pkg::*;
#(
    parameter int SEL_W        = DEF_SEL_W,
    parameter int DWELL_W      = DEF_DWELL_W,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                single,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic [2**SEL_W-1:0] code_mask,
    output logic [SEL_W-1:0]    sel,
    output logic                enable,
    output logic                code_valid,
    output logic                busy,
    output logic                done
);

    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    state_t               state_reg;
    logic [DWELL_W-1:0]   dwell_lat_reg;
    logic [2**SEL_W-1:0]  mask_lat_reg;
    logic                 single_lat_reg;
    logic [DWELL_W-1:0]   dwell_cnt_reg;
    logic [BW-1:0]        blank_cnt_reg;

    logic [2**SEL_W-1:0]  find_mask;
    logic [SEL_W-1:0]     find_above;
    logic [SEL_W-1:0]     find_lowest;
    logic                 find_last;
    logic [SEL_W-1:0]     next_code;
    logic [DWELL_W-1:0]   dwell_eff;

    // In IDLE the live mask supplies the first code; afterwards only the latched copy matters.
    assign find_mask = (state_reg == IDLE) ? code_mask : mask_lat_reg;
    assign next_code = find_last ? find_lowest : find_above;
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    next_code_finder #(
        .SEL_W(SEL_W)
    ) u_finder (
        .mask      (find_mask),
        .cur       (sel),
        .next_above(find_above),
        .lowest    (find_lowest),
        .is_last   (find_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            sel            <= '0;
            enable         <= 1'b0;
            code_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dwell_lat_reg  <= '0;
            mask_lat_reg   <= '0;
            single_lat_reg <= 1'b0;
            dwell_cnt_reg  <= '0;
            blank_cnt_reg  <= '0;
        end else begin
            code_valid <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                state_reg <= IDLE;
                enable    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && (|code_mask)) begin
                            dwell_lat_reg  <= dwell_eff;
                            mask_lat_reg   <= code_mask;
                            single_lat_reg <= single;
                            dwell_cnt_reg  <= dwell_eff;
                            sel            <= find_lowest;
                            enable         <= 1'b1;
                            code_valid     <= 1'b1;
                            busy           <= 1'b1;
                            state_reg      <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (dwell_cnt_reg > DWELL_W'(1)) begin
                            dwell_cnt_reg <= dwell_cnt_reg - DWELL_W'(1);
                        end else if (single_lat_reg && find_last) begin
                            state_reg <= DONE;
                            enable    <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (BLANK_CYCLES > 0) begin
                            state_reg     <= BLANK;
                            enable        <= 1'b0;
                            blank_cnt_reg <= BLANK_LOAD;
                        end else begin
                            sel           <= next_code;
                            code_valid    <= 1'b1;
                            dwell_cnt_reg <= dwell_lat_reg;
                        end
                    end
                    BLANK: begin
                        if (blank_cnt_reg > BW'(1)) begin
                            blank_cnt_reg <= blank_cnt_reg - BW'(1);
                        end else begin
                            state_reg     <= ACTIVE;
                            sel           <= next_code;
                            enable        <= 1'b1;
                            code_valid    <= 1'b1;
                            dwell_cnt_reg <= dwell_lat_reg;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
